// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: instruction fetch sequencer. Keeps at most one request
// outstanding to instruction memory, delivers each returned word with its
// address, holds it under downstream stall, and honours branch/exception
// redirects, discarding any in-flight fetch that a redirect made stale.
module pc_fetch_ctrl #(
    parameter logic [31:0] PC_INITIAL = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wait_stop_choke,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_valid,
    input  logic [31:0] exc_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [31:0] pending;
    logic        discard;

    logic        redirect;
    logic [31:0] tgt;
    logic [31:0] seq_addr;

    // Redirect selection (exception wins) and sequential next address
    always_comb begin
        redirect = exc_valid | br_valid;
        tgt      = exc_valid ? exc_target : br_target;
        seq_addr = ((state == HOLD) ? if_pc : req_pc) + 32'd4;
    end

    // Fetch FSM with registered memory-side and delivery-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= PC_INITIAL;
            req_pc    <= '0;
            pending   <= '0;
            discard   <= 1'b0;
            inst_req  <= 1'b0;
            inst_addr <= '0;
            if_valid  <= 1'b0;
            if_pc     <= '0;
            if_inst   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    inst_req <= 1'b1;
                    if_valid <= 1'b0;
                    if (redirect) begin
                        pc        <= tgt;
                        inst_addr <= tgt;
                    end else begin
                        inst_addr <= pc;
                    end
                end
                REQ: begin
                    if_valid <= 1'b0;
                    if (inst_addr_ok) begin
                        req_pc   <= pc;
                        inst_req <= 1'b0;
                        state    <= WAIT;
                        if (redirect) begin
                            discard <= 1'b1;
                            pending <= tgt;
                        end
                    end else if (redirect) begin
                        pc        <= tgt;
                        inst_addr <= tgt;
                    end
                end
                WAIT: begin
                    if_valid <= 1'b0;
                    if (inst_data_ok) begin
                        discard <= 1'b0;
                        if (redirect) begin
                            pc        <= tgt;
                            inst_addr <= tgt;
                            inst_req  <= 1'b1;
                            state     <= REQ;
                        end else if (discard) begin
                            pc        <= pending;
                            inst_addr <= pending;
                            inst_req  <= 1'b1;
                            state     <= REQ;
                        end else begin
                            if_valid <= 1'b1;
                            if_pc    <= req_pc;
                            if_inst  <= inst_rdata;
                            if (wait_stop_choke) begin
                                state <= HOLD;
                            end else begin
                                pc        <= seq_addr;
                                inst_addr <= seq_addr;
                                inst_req  <= 1'b1;
                                state     <= REQ;
                            end
                        end
                    end else if (redirect) begin
                        discard <= 1'b1;
                        pending <= tgt;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc        <= tgt;
                        inst_addr <= tgt;
                        inst_req  <= 1'b1;
                        if_valid  <= 1'b0;
                        state     <= REQ;
                    end else if (!wait_stop_choke) begin
                        pc        <= seq_addr;
                        inst_addr <= seq_addr;
                        inst_req  <= 1'b1;
                        if_valid  <= 1'b0;
                        state     <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed per-cycle vector table for pc_fetch_ctrl plus
// hand sequences for mid-transaction reset and PC wrap-around.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        choke = 1'b0, br_valid = 1'b0, exc_valid = 1'b0;
    logic [31:0] br_target = '0, exc_target = '0;
    logic        addr_ok = 1'b0, data_ok = 1'b0;
    logic [31:0] rdata = '0;
    logic        inst_req, if_valid;
    logic [31:0] inst_addr, if_pc, if_inst;

    // second instance for the wrap-around case
    logic        d2_aok = 1'b0, d2_dok = 1'b0;
    logic [31:0] d2_rd = '0;
    logic        d2_req, d2_valid;
    logic [31:0] d2_addr, d2_pc, d2_inst;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk(clk), .rst(rst), .wait_stop_choke(choke),
        .br_valid(br_valid), .br_target(br_target),
        .exc_valid(exc_valid), .exc_target(exc_target),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(addr_ok), .inst_data_ok(data_ok), .inst_rdata(rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
    );

    pc_fetch_ctrl #(.PC_INITIAL(32'hfffffffc)) dut2 (
        .clk(clk), .rst(rst), .wait_stop_choke(1'b0),
        .br_valid(1'b0), .br_target(32'h0),
        .exc_valid(1'b0), .exc_target(32'h0),
        .inst_req(d2_req), .inst_addr(d2_addr),
        .inst_addr_ok(d2_aok), .inst_data_ok(d2_dok), .inst_rdata(d2_rd),
        .if_valid(d2_valid), .if_pc(d2_pc), .if_inst(d2_inst)
    );

    typedef struct {
        logic        ch, br;
        logic [31:0] bt;
        logic        ex;
        logic [31:0] et;
        logic        aok, dok;
        logic [31:0] rd;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] ipc, inst;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ch, input logic br, input logic [31:0] bt,
                                input logic ex, input logic [31:0] et,
                                input logic aok, input logic dok, input logic [31:0] rd,
                                input logic req, input logic [31:0] addr, input logic v,
                                input logic [31:0] ipc, input logic [31:0] inst);
        vec_t r;
        r.ch = ch; r.br = br; r.bt = bt; r.ex = ex; r.et = et;
        r.aok = aok; r.dok = dok; r.rd = rd;
        r.req = req; r.addr = addr; r.v = v; r.ipc = ipc; r.inst = inst;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_main(input string tag, input logic req, input logic [31:0] addr,
                            input logic v, input logic [31:0] ipc, input logic [31:0] inst);
        chk({tag, ".inst_req"}, {31'b0, inst_req}, {31'b0, req});
        if (req) chk({tag, ".inst_addr"}, inst_addr, addr);
        chk({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, v});
        chk({tag, ".if_pc"}, if_pc, ipc);
        chk({tag, ".if_inst"}, if_inst, inst);
    endtask

    task automatic drive_idle();
        choke = 1'b0; br_valid = 1'b0; exc_valid = 1'b0;
        br_target = '0; exc_target = '0;
        addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ch br bt ex et aok dok rd | req addr v ipc inst
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,                 1,32'hbfc00000,0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,0,0, 1,0,0,                 0,32'h0,0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,0,0, 0,1,32'h11111111,      1,32'hbfc00004,1,32'hbfc00000,32'h11111111));
        vecs.push_back(mk(0,0,0,0,0, 1,0,0,                 0,32'h0,0,32'hbfc00000,32'h11111111));
        vecs.push_back(mk(0,0,0,0,0, 0,1,32'h22222222,      1,32'hbfc00008,1,32'hbfc00004,32'h22222222));
        vecs.push_back(mk(0,0,0,0,0, 1,0,0,                 0,32'h0,0,32'hbfc00004,32'h22222222));
        vecs.push_back(mk(1,0,0,0,0, 0,1,32'h33333333,      0,32'h0,1,32'hbfc00008,32'h33333333));
        vecs.push_back(mk(1,0,0,0,0, 0,0,0,                 0,32'h0,1,32'hbfc00008,32'h33333333));
        vecs.push_back(mk(1,0,0,0,0, 0,0,0,                 0,32'h0,1,32'hbfc00008,32'h33333333));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,                 1,32'hbfc0000c,0,32'hbfc00008,32'h33333333));
        vecs.push_back(mk(1,0,0,0,0, 0,0,0,                 1,32'hbfc0000c,0,32'hbfc00008,32'h33333333));
        vecs.push_back(mk(0,0,0,0,0, 1,0,0,                 0,32'h0,0,32'hbfc00008,32'h33333333));
        vecs.push_back(mk(0,1,32'hbfc00100,0,0, 0,0,0,      0,32'h0,0,32'hbfc00008,32'h33333333));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,                 0,32'h0,0,32'hbfc00008,32'h33333333));
        vecs.push_back(mk(0,0,0,0,0, 0,1,32'h44444444,      1,32'hbfc00100,0,32'hbfc00008,32'h33333333));
        vecs.push_back(mk(0,0,0,0,0, 1,0,0,                 0,32'h0,0,32'hbfc00008,32'h33333333));
        vecs.push_back(mk(0,0,0,0,0, 0,1,32'h55555555,      1,32'hbfc00104,1,32'hbfc00100,32'h55555555));
        vecs.push_back(mk(0,1,32'hbfc00100,1,32'hbfc00380, 0,0,0, 1,32'hbfc00380,0,32'hbfc00100,32'h55555555));
        vecs.push_back(mk(0,0,0,0,0, 1,0,0,                 0,32'h0,0,32'hbfc00100,32'h55555555));
        vecs.push_back(mk(0,0,0,0,0, 0,1,32'h66666666,      1,32'hbfc00384,1,32'hbfc00380,32'h66666666));
        vecs.push_back(mk(0,1,32'h00001000,0,0, 1,0,0,      0,32'h0,0,32'hbfc00380,32'h66666666));
        vecs.push_back(mk(0,0,0,0,0, 0,1,32'h77777777,      1,32'h00001000,0,32'hbfc00380,32'h66666666));
        vecs.push_back(mk(0,0,0,0,0, 1,0,0,                 0,32'h0,0,32'hbfc00380,32'h66666666));
        vecs.push_back(mk(0,1,32'h00002000,0,0, 0,0,0,      0,32'h0,0,32'hbfc00380,32'h66666666));
        vecs.push_back(mk(0,0,0,1,32'h00003000, 0,0,0,      0,32'h0,0,32'hbfc00380,32'h66666666));
        vecs.push_back(mk(0,0,0,0,0, 0,1,32'h88888888,      1,32'h00003000,0,32'hbfc00380,32'h66666666));
        vecs.push_back(mk(0,0,0,0,0, 1,0,0,                 0,32'h0,0,32'hbfc00380,32'h66666666));
        vecs.push_back(mk(0,1,32'h00004000,0,0, 0,1,32'h99999999, 1,32'h00004000,0,32'hbfc00380,32'h66666666));
        vecs.push_back(mk(0,0,0,0,0, 1,0,0,                 0,32'h0,0,32'hbfc00380,32'h66666666));
        vecs.push_back(mk(1,0,0,0,0, 0,1,32'haaaaaaaa,      0,32'h0,1,32'h00004000,32'haaaaaaaa));
        vecs.push_back(mk(1,1,32'h00005000,0,0, 0,0,0,      1,32'h00005000,0,32'h00004000,32'haaaaaaaa));
        vecs.push_back(mk(0,1,32'h00000123,0,0, 0,0,0,      1,32'h00000123,0,32'h00004000,32'haaaaaaaa));

        // reset state
        #3;
        chk_main("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("reset.inst_addr", inst_addr, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        foreach (vecs[i]) begin
            choke = vecs[i].ch; br_valid = vecs[i].br; br_target = vecs[i].bt;
            exc_valid = vecs[i].ex; exc_target = vecs[i].et;
            addr_ok = vecs[i].aok; data_ok = vecs[i].dok; rdata = vecs[i].rd;
            @(posedge clk);
            #1;
            chk_main($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].v,
                     vecs[i].ipc, vecs[i].inst);
            @(negedge clk);
        end

        // reset while a request is outstanding; data_ok right after release
        drive_idle();
        addr_ok = 1'b1;
        @(posedge clk); #1;
        chk("rstwait.inst_req", {31'b0, inst_req}, 32'h0);
        @(negedge clk);
        drive_idle();
        #2 rst = 1'b1;
        #1;
        chk_main("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("async_rst.inst_addr", inst_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        data_ok = 1'b1; rdata = 32'hdeadbeef;
        @(posedge clk); #1;
        chk_main("post_rst", 1'b1, 32'hbfc00000, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        drive_idle();
        addr_ok = 1'b1;
        @(posedge clk); #1;
        chk_main("post_rst_acc", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        drive_idle();
        data_ok = 1'b1; rdata = 32'hcccccccc;
        @(posedge clk); #1;
        chk_main("post_rst_data", 1'b1, 32'hbfc00004, 1'b1, 32'hbfc00000, 32'hcccccccc);
        @(negedge clk);
        drive_idle();

        // wrap-around instance has been waiting in REQ since the last reset
        chk("wrap.first_req", {31'b0, d2_req}, 32'h1);
        chk("wrap.first_addr", d2_addr, 32'hfffffffc);
        d2_aok = 1'b1;
        @(posedge clk); #1;
        chk("wrap.acc_req", {31'b0, d2_req}, 32'h0);
        @(negedge clk);
        d2_aok = 1'b0; d2_dok = 1'b1; d2_rd = 32'h12345678;
        @(posedge clk); #1;
        chk("wrap.second_req", {31'b0, d2_req}, 32'h1);
        chk("wrap.second_addr", d2_addr, 32'h00000000);
        chk("wrap.if_valid", {31'b0, d2_valid}, 32'h1);
        chk("wrap.if_pc", d2_pc, 32'hfffffffc);
        chk("wrap.if_inst", d2_inst, 32'h12345678);
        @(negedge clk);
        d2_dok = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter PC_INITIAL, default 32'hbfc00000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 wait_stop_choke  input  1  downstream stall; holds the delivered instruction.
REQ-005 br_valid  input  1  branch redirect request, single-cycle pulse.
REQ-006 br_target  input  32  branch target address.
REQ-007 exc_valid  input  1  exception redirect request, single-cycle pulse.
REQ-008 exc_target  input  32  exception vector address.
REQ-009 inst_req  output  1  fetch request to instruction memory.
REQ-010 inst_addr  output  32  fetch address, valid while inst_req=1.
REQ-011 inst_addr_ok  input  1  memory accepted request this cycle.
REQ-012 inst_data_ok  input  1  read data returned this cycle.
REQ-013 inst_rdata  input  32  returned instruction word.
REQ-014 if_valid  output  1  delivered instruction valid.
REQ-015 if_pc  output  32  address of delivered instruction.
REQ-016 if_inst  output  32  delivered instruction word.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, HOLD; at most one request outstanding.
REQ-018 IDLE SHALL go to REQ unconditionally next cycle, inst_req=0.
REQ-019 REQ: inst_req=1, inst_addr=pc; on inst_addr_ok SHALL latch req_pc=pc and go to WAIT; otherwise stay in REQ with inst_addr stable.
REQ-020 Request issue SHALL ignore wait_stop_choke; stall affects delivery only.
REQ-021 WAIT, inst_data_ok=1, discard=0: SHALL register if_inst=inst_rdata, if_pc=req_pc, if_valid=1 the following cycle.
REQ-022 Same event with wait_stop_choke=0: pc <= req_pc+4, go to REQ; with wait_stop_choke=1: go to HOLD.
REQ-023 HOLD: if_valid, if_pc, if_inst SHALL stay constant; when wait_stop_choke=0, pc <= if_pc+4, go to REQ, if_valid=0 next cycle.
REQ-024 Outside HOLD, if_valid SHALL be a one-cycle pulse per delivered instruction.
REQ-025 pc+4 SHALL wrap modulo 2^32 (32'hfffffffc -> 32'h00000000).
REQ-026 Redirect priority: exc_valid over br_valid when both asserted; selected target is "tgt".
REQ-027 Redirect in IDLE, REQ without inst_addr_ok, or HOLD: pc <= tgt, go to REQ, if_valid=0 next cycle.
REQ-028 Redirect in REQ with inst_addr_ok same cycle: SHALL go to WAIT with discard=1, pending=tgt.
REQ-029 Redirect in WAIT without inst_data_ok: discard=1, pending=tgt; a later redirect overwrites pending.
REQ-030 WAIT, inst_data_ok=1, discard=1: data SHALL be dropped (no if_valid), pc <= pending, discard=0, go to REQ.
REQ-031 Redirect and inst_data_ok same cycle in WAIT: data dropped, pc <= tgt, go to REQ.
REQ-032 tgt SHALL be used unmodified (no alignment check).

Reset
REQ-033 rst=1 SHALL asynchronously force: state=IDLE, pc=PC_INITIAL, inst_req=0, inst_addr=0, if_valid=0, if_pc=0, if_inst=0, discard=0, pending=0.
REQ-034 Reset mid-transaction SHALL abandon the outstanding request; any inst_data_ok in the first cycle after reset release SHALL be ignored.

Verification
REQ-035 Reset release, memory addr_ok/data_ok immediate -> inst_addr 32'hbfc00000, then 32'hbfc00004; if_pc tracks with one if_valid pulse each.
REQ-036 Stall held 3 cycles when data returns -> if_valid=1 with constant if_pc/if_inst for 3 cycles; next request at if_pc+4 after release.
REQ-037 br_valid (br_target=32'hbfc00100) in WAIT, data_ok 2 cycles later -> that data not delivered; next inst_addr 32'hbfc00100.
REQ-038 exc_valid (32'hbfc00380) and br_valid (32'hbfc00100) same cycle in REQ -> inst_addr 32'hbfc00380.
REQ-039 PC_INITIAL=32'hfffffffc -> second fetch at 32'h00000000.
REQ-040 rst asserted in WAIT, data_ok on first post-reset cycle -> if_valid stays 0; fetch restarts at PC_INITIAL.
